// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage, owns the PC and feeds the IF/ID latch from a combinational ROM
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] fetch_count_o
);
  logic [31:0] pc_next;
  logic        load;
  logic        bubble;
  logic        unused_stall;
  assign unused_stall = ^stall[5:3];
  // next PC by priority (enable, flush, stall, branch, sequential) and IF/ID load/bubble decisions
  always_comb begin
    pc_next = !rom_ce_o ? RESET_PC
            : flush ? {new_pc[31:2], 2'b00}
            : stall[0] ? rom_addr_o
            : branch_flag_i ? {branch_target_addr_i[31:2], 2'b00}
            : rom_addr_o + 32'd4;
    load    = rom_ce_o && !flush && !stall[1];
    bubble  = !rom_ce_o || flush || (stall[1] && !stall[2]);
  end
  // PC, chip enable, IF/ID latch and fetch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce_o      <= 1'b0;
      rom_addr_o    <= RESET_PC;
      id_pc_o       <= 32'd0;
      id_inst_o     <= 32'd0;
      fetch_count_o <= 32'd0;
    end else begin
      rom_ce_o   <= 1'b1;
      rom_addr_o <= pc_next;
      if (load) begin
        id_pc_o       <= rom_addr_o;
        id_inst_o     <= rom_inst_i;
        fetch_count_o <= fetch_count_o + 32'd1;
      end else if (bubble) begin
        id_pc_o   <= 32'd0;
        id_inst_o <= 32'd0;
      end
    end
  end
endmodule
